// File: rtl/ctrl_word_sequencer.sv
// rtl/ctrl_word_sequencer.sv - streams control words from a control SRAM onto CTRL_Signal
module ctrl_word_sequencer #(
  parameter int CTRL_WIDTH = 72,
  parameter int PC_WIDTH = 10,
  parameter logic [CTRL_WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                  CLK_100,
  input  logic                  locked,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pause,
  input  logic [PC_WIDTH-1:0]   prog_base,
  input  logic [PC_WIDTH-1:0]   prog_len,
  output logic [PC_WIDTH-1:0]   imem_addr,
  output logic                  imem_csb,
  input  logic [CTRL_WIDTH-1:0] imem_dout,
  output logic [CTRL_WIDTH-1:0] CTRL_Signal,
  output logic                  ctrl_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len,
  output logic [PC_WIDTH:0]     word_count
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH:0]     r_limit;
  logic [PC_WIDTH:0]     r_count;
  logic [CTRL_WIDTH-1:0] r_skid;
  logic                  r_skid_v;
  logic                  r_rd_pend;
  logic                  r_stop;
  logic [CTRL_WIDTH-1:0] r_ctrl;
  logic                  r_valid;
  logic                  r_done;
  logic                  r_err;

  logic                  w_read;
  logic                  w_avail;
  logic [CTRL_WIDTH-1:0] w_word;
  logic [PC_WIDTH:0]     w_cnt_nxt;
  logic [PC_WIDTH-1:0]   w_pc_nxt;
  logic                  w_last;

  // r_stop marks the cycle after the final word: no further reads, next state is DRAIN
  assign w_read    = (r_state == S_FETCH) || ((r_state == S_RUN) && !pause && !r_stop);
  assign imem_csb  = ~w_read;
  assign imem_addr = r_pc;

  assign w_avail   = r_skid_v | r_rd_pend;
  assign w_word    = r_skid_v ? r_skid : imem_dout;
  assign w_cnt_nxt = r_count + {{PC_WIDTH{1'b0}}, 1'b1};
  assign w_pc_nxt  = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign w_last    = w_word[0] || (w_cnt_nxt == r_limit);

  assign CTRL_Signal = r_ctrl;
  assign ctrl_valid  = r_valid;
  assign busy        = (r_state == S_FETCH) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = r_done;
  assign err_len     = r_err;
  assign word_count  = r_count;

  always_ff @(posedge CLK_100 or negedge locked) begin
    if (!locked) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_limit   <= '0;
      r_count   <= '0;
      r_skid    <= IDLE_WORD;
      r_skid_v  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_stop    <= 1'b0;
      r_ctrl    <= IDLE_WORD;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rd_pend <= w_read;
      if (abort) begin
        r_state  <= S_IDLE;
        r_ctrl   <= IDLE_WORD;
        r_valid  <= 1'b0;
        r_skid_v <= 1'b0;
        r_stop   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_pc     <= prog_base;
              r_limit  <= (prog_len == '0) ? {1'b1, {PC_WIDTH{1'b0}}} : {1'b0, prog_len};
              r_count  <= '0;
              r_done   <= 1'b0;
              r_err    <= 1'b0;
              r_skid_v <= 1'b0;
              r_stop   <= 1'b0;
              r_state  <= S_FETCH;
            end
          end
          S_FETCH: begin
            r_pc    <= w_pc_nxt;
            r_state <= S_RUN;
          end
          S_RUN: begin
            if (r_stop) begin
              r_ctrl  <= IDLE_WORD;
              r_valid <= 1'b0;
              r_stop  <= 1'b0;
              r_state <= S_DRAIN;
            end else if (pause) begin
              // the read issued last cycle is still returning; park it
              r_ctrl  <= IDLE_WORD;
              r_valid <= 1'b0;
              if (r_rd_pend) begin
                r_skid   <= imem_dout;
                r_skid_v <= 1'b1;
              end
            end else begin
              r_pc <= w_pc_nxt;
              if (w_avail) begin
                r_ctrl   <= w_word;
                r_valid  <= 1'b1;
                r_count  <= w_cnt_nxt;
                r_skid_v <= 1'b0;
                if (w_last) begin
                  r_stop <= 1'b1;
                  r_err  <= ~w_word[0];
                end
              end else begin
                r_ctrl  <= IDLE_WORD;
                r_valid <= 1'b0;
              end
            end
          end
          S_DRAIN: begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// tb/tb_ctrl_word_sequencer.sv - self-checking bench for ctrl_word_sequencer
module tb_ctrl_word_sequencer;

  logic        CLK_100 = 1'b0;
  logic        locked;
  logic        start;
  logic        abort;
  logic        pause;
  logic [9:0]  prog_base;
  logic [9:0]  prog_len;
  logic [9:0]  imem_addr;
  logic        imem_csb;
  logic [71:0] imem_dout;
  logic [71:0] CTRL_Signal;
  logic        ctrl_valid;
  logic        busy;
  logic        done;
  logic        err_len;
  logic [10:0] word_count;

  logic [71:0] mem [0:1023];
  int n_vec = 0;
  int n_fail = 0;
  logic [71:0] w0, w1, w2, w3;

  always #5 CLK_100 = ~CLK_100;

  // control SRAM: data valid one cycle after the address is sampled
  always @(posedge CLK_100) if (!imem_csb) imem_dout <= mem[imem_addr];

  ctrl_word_sequencer dut (
    .CLK_100(CLK_100), .locked(locked), .start(start), .abort(abort), .pause(pause),
    .prog_base(prog_base), .prog_len(prog_len), .imem_addr(imem_addr), .imem_csb(imem_csb),
    .imem_dout(imem_dout), .CTRL_Signal(CTRL_Signal), .ctrl_valid(ctrl_valid), .busy(busy),
    .done(done), .err_len(err_len), .word_count(word_count)
  );

  task automatic tick();
    @(posedge CLK_100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] rnd_word(input logic last);
    logic [71:0] w;
    w = {8'($urandom), $urandom, $urandom};
    w[0] = last;
    return w;
  endfunction

  // Reference: walk memory from base until a bit-0 word or the length limit.
  task automatic run_prog(input logic [9:0] base, input logic [9:0] len, input int pause_pct,
                          input string tag);
    logic [71:0] exp_q[$];
    logic [71:0] got_q[$];
    logic        exp_err;
    int          lim;
    bit          fin;
    logic [71:0] w;
    exp_err = 1'b0;
    lim = (len == 10'd0) ? 1024 : int'(len);
    for (int i = 0; i < 1024; i++) begin
      w = mem[base + 10'(i)];
      exp_q.push_back(w);
      if (w[0]) break;
      if (i + 1 == lim) begin
        exp_err = 1'b1;
        break;
      end
    end
    prog_base = base;
    prog_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      pause = ($urandom_range(99) < pause_pct);
      tick();
      if (ctrl_valid) got_q.push_back(CTRL_Signal);
      else chk({tag, " idle_word"}, 128'(CTRL_Signal), 128'(72'h0));
      if (done) fin = 1'b1;
    end
    pause = 1'b0;
    chk({tag, " done"}, 128'(done), 128'(1'b1));
    chk({tag, " n_words"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (k < got_q.size()) chk({tag, " word"}, 128'(got_q[k]), 128'(exp_q[k]));
    chk({tag, " err_len"}, 128'(err_len), 128'(exp_err));
    chk({tag, " word_count"}, 128'(word_count), 128'(exp_q.size()));
  endtask

  initial begin
    locked = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
    prog_base = '0; prog_len = '0;
    for (int i = 0; i < 1024; i++) mem[i] = rnd_word(1'b0);
    tick();
    tick();
    chk("rst ctrl", 128'(CTRL_Signal), 128'(72'h0));
    chk("rst valid", 128'(ctrl_valid), 128'(1'b0));
    chk("rst busy", 128'(busy), 128'(1'b0));
    chk("rst done", 128'(done), 128'(1'b0));
    chk("rst err", 128'(err_len), 128'(1'b0));
    chk("rst csb", 128'(imem_csb), 128'(1'b1));
    chk("rst addr", 128'(imem_addr), 128'(10'h0));
    chk("rst count", 128'(word_count), 128'(11'h0));
    locked = 1'b1;
    tick();

    // normal run with exact latency: start in cycle t, word0 at t+3
    w0 = rnd_word(1'b0); w1 = rnd_word(1'b0); w2 = rnd_word(1'b0); w3 = rnd_word(1'b1);
    mem[10'h010] = w0; mem[10'h011] = w1; mem[10'h012] = w2; mem[10'h013] = w3;
    prog_base = 10'h010; prog_len = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("norm w0", 128'(CTRL_Signal), 128'(w0)); chk("norm v0", 128'(ctrl_valid), 128'(1'b1));
    tick();
    chk("norm w1", 128'(CTRL_Signal), 128'(w1)); chk("norm v1", 128'(ctrl_valid), 128'(1'b1));
    tick();
    chk("norm w2", 128'(CTRL_Signal), 128'(w2)); chk("norm v2", 128'(ctrl_valid), 128'(1'b1));
    tick();
    chk("norm w3", 128'(CTRL_Signal), 128'(w3)); chk("norm v3", 128'(ctrl_valid), 128'(1'b1));
    tick();
    chk("norm idle", 128'(CTRL_Signal), 128'(72'h0)); chk("norm v_off", 128'(ctrl_valid), 128'(1'b0));
    chk("norm done_early", 128'(done), 128'(1'b0));
    tick();
    chk("norm done", 128'(done), 128'(1'b1)); chk("norm busy", 128'(busy), 128'(1'b0));
    chk("norm count", 128'(word_count), 128'(11'd4)); chk("norm err", 128'(err_len), 128'(1'b0));

    // pause for two cycles while w1 is on CTRL_Signal
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pause w1", 128'(CTRL_Signal), 128'(w1));
    pause = 1'b1;
    tick();
    chk("pause idle0", 128'(ctrl_valid), 128'(1'b0)); chk("pause word0", 128'(CTRL_Signal), 128'(72'h0));
    tick();
    pause = 1'b0;
    chk("pause idle1", 128'(ctrl_valid), 128'(1'b0)); chk("pause word1", 128'(CTRL_Signal), 128'(72'h0));
    tick();
    chk("pause w2", 128'(CTRL_Signal), 128'(w2)); chk("pause v2", 128'(ctrl_valid), 128'(1'b1));
    tick();
    chk("pause w3", 128'(CTRL_Signal), 128'(w3)); chk("pause v3", 128'(ctrl_valid), 128'(1'b1));
    tick(); tick();
    chk("pause count", 128'(word_count), 128'(11'd4)); chk("pause done", 128'(done), 128'(1'b1));

    // abort while w1 is on CTRL_Signal, then restart cleanly
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort w1", 128'(CTRL_Signal), 128'(w1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort ctrl", 128'(CTRL_Signal), 128'(72'h0)); chk("abort valid", 128'(ctrl_valid), 128'(1'b0));
    chk("abort busy", 128'(busy), 128'(1'b0)); chk("abort done", 128'(done), 128'(1'b0));
    chk("abort csb", 128'(imem_csb), 128'(1'b1)); chk("abort count", 128'(word_count), 128'(11'd2));
    run_prog(10'h010, 10'd0, 0, "restart");

    // length limit and wrap with zero length
    for (int i = 0; i < 8; i++) mem[10'h020 + 10'(i)] = rnd_word(1'b0);
    run_prog(10'h020, 10'd3, 0, "limit");
    mem[10'h3FE] = rnd_word(1'b0); mem[10'h3FF] = rnd_word(1'b0);
    mem[10'h000] = rnd_word(1'b0); mem[10'h001] = rnd_word(1'b1);
    run_prog(10'h3FE, 10'd0, 0, "wrap");
    mem[10'h031] = rnd_word(1'b1);
    for (int i = 0; i < 3; i++) mem[10'h02E + 10'(i)] = rnd_word(1'b0);
    run_prog(10'h02E, 10'd4, 0, "flag_at_limit");

    // asynchronous reset in the middle of a cycle
    prog_base = 10'h020; prog_len = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #3 locked = 1'b0;
    #1;
    chk("arst ctrl", 128'(CTRL_Signal), 128'(72'h0)); chk("arst valid", 128'(ctrl_valid), 128'(1'b0));
    chk("arst busy", 128'(busy), 128'(1'b0)); chk("arst csb", 128'(imem_csb), 128'(1'b1));
    chk("arst addr", 128'(imem_addr), 128'(10'h0)); chk("arst count", 128'(word_count), 128'(11'h0));
    #2 locked = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("arst quiet", 128'({busy, ctrl_valid}), 128'(2'b00));
    end

    // randomized programs with random pause
    for (int i = 0; i < 1024; i++) mem[i] = rnd_word($urandom_range(7) == 0);
    for (int r = 0; r < 12; r++)
      run_prog(10'($urandom), ($urandom_range(3) == 0) ? 10'd0 : 10'($urandom_range(12, 1)),
               30, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_word_sequencer.md
Name: ctrl_word_sequencer

Overview:
- Produces the CTRL_Signal stream that LUD datapath blocks consume: one control word per cycle, issued back-to-back.
- Fetches control words from a single-port control SRAM (DATA-style macro: active-low csb, read data valid one cycle after the address is sampled) and registers each word onto CTRL_Signal.
- Started, paused and aborted by the ZYNQ side. Stops on the "complete" flag in bit 0 of a word, or on a length limit.

Parameters:
- CTRL_WIDTH, 72, width of one control word and of CTRL_Signal.
- PC_WIDTH, 10, control-SRAM address width.
- IDLE_WORD, 0, word driven on CTRL_Signal when no valid word is present.

Ports:
- CLK_100  in  1  system clock.
- locked  in  1  asynchronous active-low reset (0 = reset).
- start  in  1  one-cycle pulse; honoured in IDLE or DONE only.
- abort  in  1  level; forces IDLE from any state.
- pause  in  1  level; stalls the stream while high.
- prog_base  in  PC_WIDTH  first control-word address; sampled on start.
- prog_len  in  PC_WIDTH  maximum words to emit; sampled on start; 0 means 2^PC_WIDTH.
- imem_addr  out  PC_WIDTH  control-SRAM address.
- imem_csb  out  1  control-SRAM chip select, active low.
- imem_dout  in  CTRL_WIDTH  control-SRAM read data.
- CTRL_Signal  out  CTRL_WIDTH  registered control word to the datapath.
- ctrl_valid  out  1  CTRL_Signal holds a program word this cycle.
- busy  out  1  high in FETCH, RUN and DRAIN.
- done  out  1  sticky; set on normal or error completion; cleared by start.
- err_len  out  1  sticky; prog_len words emitted with no bit-0 flag; cleared by start.
- word_count  out  PC_WIDTH+1  words emitted since the last start.

Behaviour:
- Reset (locked=0, asynchronous) values:
  - state=IDLE; CTRL_Signal=IDLE_WORD.
  - ctrl_valid, busy, done, err_len = 0.
  - imem_csb=1; imem_addr=0; word_count=0; skid register empty.
- Reset mid-run: outputs take the reset values immediately; the program is not resumed.
- States:
  - IDLE/DONE: csb=1; CTRL_Signal=IDLE_WORD. On start: pc<=prog_base, clear done, err_len and word_count, go to FETCH.
  - FETCH (1 cycle): imem_addr=pc, csb=0, pc++, go to RUN.
  - RUN:
    - Each non-paused cycle: issue a read at pc (pc++, wraps modulo 2^PC_WIDTH).
    - Register the returning imem_dout, or the skid word if one is held, into CTRL_Signal with ctrl_valid=1.
    - word_count increments per emitted word.
  - DRAIN (1 cycle): CTRL_Signal=IDLE_WORD, ctrl_valid=0, csb=1, set done, go to DONE.
- Latency: start high in cycle t gives word0 on CTRL_Signal in cycle t+3. Words then follow one per cycle with no gaps unless paused.
- Termination: when the word being registered has bit0=1, or is word number prog_len, it is emitted and the state goes to DRAIN.
  - The prefetched word beyond it is discarded.
  - err_len=1 only if the limit is reached and bit0=0.
  - If bit0=1 on exactly the limit word: normal completion, err_len=0.
- Pause:
  - While pause=1: csb=1, pc held, CTRL_Signal=IDLE_WORD, ctrl_valid=0.
  - A read already in flight when pause rises is captured into the one-entry skid register.
  - On resume the skid word is emitted first, in the same cycle the next read issues, so no word is lost or duplicated.
  - Pause during FETCH takes effect after the FETCH read, which goes to the skid.
  - Pause in IDLE/DONE/DRAIN is ignored.
- Abort:
  - On the next edge: CTRL_Signal=IDLE_WORD, ctrl_valid=0, csb=1, skid cleared, state=IDLE.
  - done is not set; word_count is held.
  - Abort has priority over start and pause in the same cycle.
- start while busy: ignored.
- pc wrap past 2^PC_WIDTH-1 to 0: legal, no flag.

Test Plan:
- Normal run: prog_base=0x010; SRAM words W0..W3 with W3 bit0=1; start pulse at t → CTRL_Signal=W0..W3 in t+3..t+6, ctrl_valid=1 for those cycles; IDLE_WORD at t+7; done=1 from t+8; word_count=4; err_len=0.
- Length limit: prog_len=3, no bit0 set in the program → exactly three words emitted; done=1, err_len=1, word_count=3.
- Pause: raise pause for 2 cycles while W1 is on CTRL_Signal → two IDLE_WORD cycles with ctrl_valid=0, then W2, W3 in order; no duplicate or missing word; word_count=4.
- Abort: assert abort while W1 is on CTRL_Signal → next cycle IDLE_WORD, busy=0, done=0, imem_csb=1; a following start restarts cleanly from prog_base.
- Wrap and zero length: prog_base=0x3FE, prog_len=0, end flag at address 0x001 → words fetched from 0x3FE, 0x3FF, 0x000, 0x001; word_count=4, done=1.
- Async reset: pull locked low mid-RUN, between clock edges → all outputs reach reset values without waiting for a clock edge; with start held low, nothing is emitted after reset releases.
